// File: rtl/sys_psum_acc.sv
// Per-column psum capture behind the systolic array, K-tile accumulation, aligned row drain.
// Optional saturating accumulate: define MMU_ACC_SAT_EN.
module sys_psum_acc #(
  parameter  int SYS_COL    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int ACC_WIDTH  = 40,
  parameter  int ACC_DEPTH  = 64,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
  localparam int ADDR_W     = $clog2(ACC_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                acc_first,
  input  logic                                drain,
  input  logic [ADDR_W:0]                     tile_len,
  input  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]  psum_in,
  input  logic [SYS_COL-1:0]                  en_in,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SYS_COL-1:0][ACC_WIDTH-1:0]   out_data,
  output logic                                out_last,
  output logic                                err,
  output logic                                ovf
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                 cfg_first;
  logic                 cfg_drain;
  logic [CW-1:0]        cfg_len;
  logic [CW-1:0]        wcnt [SYS_COL];
  logic [ADDR_W-1:0]    rcnt;
  logic [ACC_WIDTH-1:0] mem  [SYS_COL][ACC_DEPTH];

  logic [SYS_COL-1:0]          wr_en;
  logic [SYS_COL-1:0]          col_done;
  logic [ACC_WIDTH-1:0]        wr_data [SYS_COL];
  logic signed [ACC_WIDTH-1:0] cur     [SYS_COL];
  logic signed [ACC_WIDTH-1:0] ext     [SYS_COL];
`ifdef MMU_ACC_SAT_EN
  logic signed [ACC_WIDTH:0]   sum     [SYS_COL];
  logic [SYS_COL-1:0]          col_ovf;
`else
  logic signed [ACC_WIDTH-1:0] sum     [SYS_COL];
`endif

  logic len_ok;
  logic start_ok;
  logic ign_en;
  logic err_set;
  logic fill_done;
  logic last_row;

  assign len_ok    = (tile_len != '0) && (tile_len <= CW'(ACC_DEPTH));
  assign start_ok  = start && (state_q == IDLE);
  assign ign_en    = |(en_in & ~wr_en);
  assign err_set   = ign_en || (start && state_q != IDLE) || (start_ok && !len_ok);
  assign fill_done = &col_done;
  assign last_row  = {1'b0, rcnt} == (cfg_len - CW'(1));
  assign busy      = state_q != IDLE;
  assign out_last  = out_valid && last_row;

  // Read-modify-write per column, each on its own write pointer
  always_comb begin
`ifdef MMU_ACC_SAT_EN
    col_ovf = '0;
`endif
    for (int c = 0; c < SYS_COL; c++) begin
      wr_en[c]    = (state_q == FILL) && en_in[c] && (wcnt[c] != cfg_len);
      col_done[c] = (wcnt[c] + CW'(wr_en[c])) == cfg_len;
      cur[c]      = $signed(mem[c][wcnt[c][ADDR_W-1:0]]);
      ext[c]      = ACC_WIDTH'($signed(psum_in[c]));
`ifdef MMU_ACC_SAT_EN
      sum[c]      = (ACC_WIDTH+1)'(cur[c]) + (ACC_WIDTH+1)'(ext[c]);
      wr_data[c]  = sum[c][ACC_WIDTH-1:0];
      if (cfg_first) begin
        wr_data[c] = ext[c];
      end else if (sum[c][ACC_WIDTH] != sum[c][ACC_WIDTH-1]) begin
        col_ovf[c] = wr_en[c];
        wr_data[c] = sum[c][ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
`else
      sum[c]      = cur[c] + ext[c];
      wr_data[c]  = cfg_first ? ext[c] : sum[c];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok && len_ok) state_d = FILL;
      FILL:    if (fill_done) state_d = cfg_drain ? DRAIN : IDLE;
      DRAIN:   if (out_valid && out_ready && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_first <= 1'b0;
      cfg_drain <= 1'b0;
      cfg_len   <= '0;
      err       <= 1'b0;
      for (int c = 0; c < SYS_COL; c++) wcnt[c] <= '0;
    end else begin
      if (start_ok)     err <= err_set;
      else if (err_set) err <= 1'b1;
      if (start_ok && len_ok) begin
        cfg_first <= acc_first;
        cfg_drain <= drain;
        cfg_len   <= tile_len;
        for (int c = 0; c < SYS_COL; c++) wcnt[c] <= '0;
      end else begin
        for (int c = 0; c < SYS_COL; c++)
          if (wr_en[c]) wcnt[c] <= wcnt[c] + CW'(1);
      end
    end
  end

`ifdef MMU_ACC_SAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          ovf <= 1'b0;
    else if (start_ok)  ovf <= 1'b0;
    else if (|col_ovf)  ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

  // Accumulator storage has no reset; first tile must overwrite
  always_ff @(posedge clk) begin
    for (int c = 0; c < SYS_COL; c++)
      if (wr_en[c]) mem[c][wcnt[c][ADDR_W-1:0]] <= wr_data[c];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      rcnt      <= '0;
      out_data  <= '0;
    end else if (state_q != DRAIN) begin
      out_valid <= 1'b0;
      rcnt      <= '0;
    end else if (!out_valid) begin
      out_valid <= 1'b1;
      for (int c = 0; c < SYS_COL; c++) out_data[c] <= mem[c][rcnt];
    end else if (out_ready) begin
      if (last_row) begin
        out_valid <= 1'b0;
      end else begin
        rcnt <= rcnt + ADDR_W'(1);
        for (int c = 0; c < SYS_COL; c++)
          out_data[c] <= mem[c][rcnt + ADDR_W'(1)];
      end
    end
  end

endmodule
